// File: rtl/histogram_pipelined_pkg.sv
// Shared types and constants for the pipelined histogram kernel.
package histogram_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } hist_state_t;

  // Cycles needed after the last issue for S1 and S2 to empty.
  localparam int HIST_DRAIN_CYCLES = 2;

endpackage

// File: rtl/histogram_pipelined_if.sv
// Control handshake plus sample-RAM and bin-RAM ports of the histogram kernel.
interface histogram_pipelined_if #(
  parameter int DATA_W  = 8,
  parameter int BIN_W   = 8,
  parameter int COUNT_W = 32,
  parameter int ADDR_W  = 12
);

  logic               start;
  logic               clear_first;
  logic [ADDR_W:0]    num_samples;
  logic               busy;
  logic               valid;
  logic               saturated;
  logic [ADDR_W-1:0]  in_raddr;
  logic [DATA_W-1:0]  in_rdata;
  logic [BIN_W-1:0]   bin_raddr;
  logic [COUNT_W-1:0] bin_rdata;
  logic [BIN_W-1:0]   bin_waddr;
  logic [COUNT_W-1:0] bin_wdata;
  logic               bin_wen;

  // Controller plus RAMs: everything that surrounds the kernel.
  modport master (
    output start, clear_first, num_samples, in_rdata, bin_rdata,
    input  busy, valid, saturated, in_raddr, bin_raddr, bin_waddr,
           bin_wdata, bin_wen
  );

  // The kernel itself.
  modport slave (
    input  start, clear_first, num_samples, in_rdata, bin_rdata,
    output busy, valid, saturated, in_raddr, bin_raddr, bin_waddr,
           bin_wdata, bin_wen
  );

endinterface

// File: rtl/histogram_pipelined_sat_incr.sv
// Forward mux, saturating +1 and clamp flag for the S2 read-modify-write stage.
module hist_sat_incr #(
  parameter int COUNT_W = 32
) (
  input  logic               i_use_fwd,
  input  logic [COUNT_W-1:0] i_fwd_data,
  input  logic [COUNT_W-1:0] i_rd_data,
  output logic [COUNT_W-1:0] o_next,
  output logic               o_sat
);

  logic [COUNT_W-1:0] w_cur;

  // Pick the freshest copy of the bin, then increment unless already full.
  always_comb begin
    w_cur  = i_use_fwd ? i_fwd_data : i_rd_data;
    o_sat  = &w_cur;
    o_next = o_sat ? w_cur : w_cur + COUNT_W'(1);
  end

endmodule

// File: rtl/histogram_pipelined.sv
// Pipelined histogram kernel: optional bin clear, II=1 read-modify-write over
// an external bin RAM with one-deep write-to-read forwarding, saturating counts.
module histogram_pipelined
  import histogram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIN_W   = 8,
  parameter int COUNT_W = 32,
  parameter int ADDR_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  histogram_pipelined_if.slave bus
);

  if (BIN_W > DATA_W) begin : g_bad_bin_w
    $error("histogram_pipelined: BIN_W must not exceed DATA_W");
  end

  localparam logic [BIN_W-1:0]  LAST_BIN   = '1;
  localparam logic [ADDR_W:0]   IDX_ONE    = 1;
  localparam logic [BIN_W-1:0]  BIN_ONE    = 1;
  localparam logic [1:0]        DRAIN_LAST = 2'(HIST_DRAIN_CYCLES - 1);

  hist_state_t        r_state;
  hist_state_t        w_next_state;

  logic [ADDR_W:0]    r_num;
  logic [ADDR_W:0]    r_idx;
  logic [BIN_W-1:0]   r_clr_idx;
  logic [1:0]         r_drain_cnt;
  logic               r_saturated;

  logic               r_s1_valid;
  logic               r_s2_valid;
  logic [BIN_W-1:0]   r_s2_bin;
  logic               r_fwd_valid;
  logic [BIN_W-1:0]   r_fwd_bin;
  logic [COUNT_W-1:0] r_fwd_data;

  logic               w_start_ok;
  logic               w_last_issue;
  logic [BIN_W-1:0]   w_s1_bin;
  logic               w_use_fwd;
  logic [COUNT_W-1:0] w_s2_next;
  logic               w_s2_sat;

  assign w_start_ok   = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_last_issue = (r_idx + IDX_ONE) == r_num;
  assign w_s1_bin     = bus.in_rdata[DATA_W-1 -: BIN_W];
  assign w_use_fwd    = r_fwd_valid && (r_fwd_bin == r_s2_bin);

  hist_sat_incr #(
    .COUNT_W (COUNT_W)
  ) u_sat_incr (
    .i_use_fwd  (w_use_fwd),
    .i_fwd_data (r_fwd_data),
    .i_rd_data  (bus.bin_rdata),
    .o_next     (w_s2_next),
    .o_sat      (w_s2_sat)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic; start is honoured only from IDLE or DONE.
  // NOTE: the default assignment on entry keeps this purely combinational;
  // without it, any path that skips an assignment would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start_ok) begin
          if (bus.clear_first)           w_next_state = CLEAR;
          else if (bus.num_samples == '0) w_next_state = DONE;
          else                           w_next_state = RUN;
        end
      end
      CLEAR: begin
        if (r_clr_idx == LAST_BIN) w_next_state = (r_num == '0) ? DONE : RUN;
      end
      RUN: begin
        if (w_last_issue) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: every address/data/enable is forced to 0 when its stage is idle.
  always_comb begin
    bus.busy      = (r_state == CLEAR) || (r_state == RUN) || (r_state == DRAIN);
    bus.valid     = (r_state == DONE);
    bus.saturated = r_saturated;
    bus.in_raddr  = (r_state == RUN) ? r_idx[ADDR_W-1:0] : '0;
    bus.bin_raddr = r_s1_valid ? w_s1_bin : '0;
    bus.bin_wen   = 1'b0;
    bus.bin_waddr = '0;
    bus.bin_wdata = '0;
    if (r_state == CLEAR) begin
      bus.bin_wen   = 1'b1;
      bus.bin_waddr = r_clr_idx;
    end else if (r_s2_valid) begin
      bus.bin_wen   = 1'b1;
      bus.bin_waddr = r_s2_bin;
      bus.bin_wdata = w_s2_next;
    end
  end

  // Run bookkeeping: latched count, issue/clear/drain counters, sticky clamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num       <= '0;
      r_idx       <= '0;
      r_clr_idx   <= '0;
      r_drain_cnt <= '0;
      r_saturated <= 1'b0;
    end else begin
      if (w_start_ok) r_num <= bus.num_samples;
      r_idx       <= (r_state == RUN)   ? r_idx + IDX_ONE       : '0;
      r_clr_idx   <= (r_state == CLEAR) ? r_clr_idx + BIN_ONE   : '0;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1    : '0;
      if (w_start_ok)                  r_saturated <= 1'b0;
      else if (r_s2_valid && w_s2_sat) r_saturated <= 1'b1;
    end
  end

  // Pipeline valids, S2 bin and forward register. Bin counts live in the
  // external RAM.
  // NOTE: only these control/forward flops are reset; the bin storage is a RAM
  // outside the block and is deliberately left untouched by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_bin    <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_bin   <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_s1_valid  <= (r_state == RUN);
      r_s2_valid  <= r_s1_valid;
      r_s2_bin    <= r_s1_valid ? w_s1_bin : '0;
      r_fwd_valid <= r_s2_valid;
      r_fwd_bin   <= r_s2_valid ? r_s2_bin : '0;
      r_fwd_data  <= r_s2_valid ? w_s2_next : '0;
    end
  end

endmodule

// File: tb/tb_histogram_pipelined.sv
// Directed self-checking bench for histogram_pipelined: default instance plus
// a COUNT_W=4 instance for saturation, each with its own sample and bin RAMs.
module tb_histogram_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  histogram_pipelined_if                 bus ();
  histogram_pipelined_if #(.COUNT_W(4))  bus_s ();

  histogram_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  histogram_pipelined #(.COUNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  logic [7:0]  smem   [4096];
  logic [7:0]  smem_s [4096];
  logic [31:0] bmem   [256];
  logic [3:0]  bmem_s [256];

  // Synchronous RAM models; bin RAMs return old data on read-during-write.
  always @(posedge clk) begin
    bus.in_rdata    <= smem[bus.in_raddr];
    bus.bin_rdata   <= bmem[bus.bin_raddr];
    if (bus.bin_wen) bmem[bus.bin_waddr] <= bus.bin_wdata;
    bus_s.in_rdata  <= smem_s[bus_s.in_raddr];
    bus_s.bin_rdata <= bmem_s[bus_s.bin_raddr];
    if (bus_s.bin_wen) bmem_s[bus_s.bin_waddr] <= bus_s.bin_wdata;
  end

  int cyc      = 0;
  int wen_cnt  = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bin_wen) wen_cnt  <= wen_cnt + 1;
    if (bus.busy)    busy_cnt <= busy_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  int t_start;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle on the selected instance; returns in cycle t+1.
  task automatic do_start(input bit sel, input bit clr, input int n);
    if (sel) begin
      bus_s.clear_first = clr;
      bus_s.num_samples = 13'(n);
      bus_s.start       = 1'b1;
    end else begin
      bus.clear_first = clr;
      bus.num_samples = 13'(n);
      bus.start       = 1'b1;
    end
    t_start = cyc;
    step();
    bus.start   = 1'b0;
    bus_s.start = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int max, output int vc);
    vc = -1;
    for (int k = 0; k < max; k++) begin
      if (sel ? bus_s.valid : bus.valid) begin
        vc = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL reset_busy_valid: got %b%b expected 00", bus.busy, bus.valid);
    end
    checks++;
    if (bus.saturated !== 1'b0 || bus_s.saturated !== 1'b0) begin
      errors++; $display("FAIL reset_saturated: got %b%b expected 00", bus.saturated, bus_s.saturated);
    end
    checks++;
    if (bus.in_raddr !== 12'h0 || bus.bin_raddr !== 8'h0) begin
      errors++; $display("FAIL reset_raddr: got %h/%h expected 0/0", bus.in_raddr, bus.bin_raddr);
    end
    checks++;
    if (bus.bin_wen !== 1'b0 || bus.bin_waddr !== 8'h0 || bus.bin_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_write: got %b/%h/%h expected 0/0/0", bus.bin_wen, bus.bin_waddr, bus.bin_wdata);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", bus.busy, bus.valid);
    end
  endtask

  task automatic test_zero_samples();
    int w0, b0;
    w0 = wen_cnt;
    b0 = busy_cnt;
    do_start(1'b0, 1'b0, 0);
    checks++;
    if (bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_valid_t1: got valid=%b busy=%b expected 1 0", bus.valid, bus.busy);
    end
    step(); step(); step();
    checks++;
    if (wen_cnt - w0 !== 0) begin
      errors++; $display("FAIL zero_no_write: got %0d writes expected 0", wen_cnt - w0);
    end
    checks++;
    if (busy_cnt - b0 !== 0) begin
      errors++; $display("FAIL zero_no_busy: got %0d busy cycles expected 0", busy_cnt - b0);
    end
  endtask

  task automatic check_bins_3_7(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (k != 3 && k != 7 && bmem[k] !== 32'h0) bad++;
    checks++;
    if (bmem[3] !== 32'd3) begin
      errors++; $display("FAIL %s_bin3: got %0d expected 3", tag, bmem[3]);
    end
    checks++;
    if (bmem[7] !== 32'd1) begin
      errors++; $display("FAIL %s_bin7: got %0d expected 1", tag, bmem[7]);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL %s_other_bins: got %0d nonzero expected 0", tag, bad);
    end
  endtask

  task automatic test_clear_run();
    int w0, vc;
    for (int k = 0; k < 256; k++) bmem[k] <= 32'hDEAD_BEEF;
    smem[0] <= 8'd3; smem[1] <= 8'd7; smem[2] <= 8'd3; smem[3] <= 8'd3;
    w0 = wen_cnt;
    do_start(1'b0, 1'b1, 4);
    checks++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL clear_busy_t1: got busy=%b valid=%b expected 1 0", bus.busy, bus.valid);
    end
    checks++;
    if (bus.bin_wen !== 1'b1 || bus.bin_waddr !== 8'h00 || bus.bin_wdata !== 32'h0) begin
      errors++; $display("FAIL clear_first_write: got %b/%h/%h expected 1/00/0", bus.bin_wen, bus.bin_waddr, bus.bin_wdata);
    end
    wait_valid(1'b0, 400, vc);
    checks++;
    if (vc !== t_start + 263) begin
      errors++; $display("FAIL clear_valid_time: got %0d expected %0d", vc, t_start + 263);
    end
    checks++;
    if (wen_cnt - w0 !== 260) begin
      errors++; $display("FAIL clear_write_count: got %0d expected 260", wen_cnt - w0);
    end
    checks++;
    if (bus.saturated !== 1'b0) begin
      errors++; $display("FAIL clear_no_sat: got %b expected 0", bus.saturated);
    end
    check_bins_3_7("clear");
  endtask

  task automatic test_back_to_back();
    logic        e_busy, e_valid, e_wen;
    logic [11:0] e_raddr;
    logic [7:0]  e_waddr;
    logic [31:0] e_wdata;
    for (int k = 0; k < 256; k++) bmem[k] <= 32'h0;
    for (int k = 0; k < 6; k++) smem[k] <= 8'h55;
    do_start(1'b0, 1'b0, 6);
    for (int k = 1; k <= 9; k++) begin
      e_busy  = (k <= 8);
      e_valid = (k == 9);
      e_raddr = (k <= 6) ? 12'(k - 1) : 12'h0;
      e_wen   = (k >= 3 && k <= 8);
      e_waddr = e_wen ? 8'h55 : 8'h00;
      e_wdata = e_wen ? 32'(k - 2) : 32'h0;
      checks++;
      if (bus.busy !== e_busy) begin
        errors++; $display("FAIL b2b_busy[t+%0d]: got %b expected %b", k, bus.busy, e_busy);
      end
      checks++;
      if (bus.valid !== e_valid) begin
        errors++; $display("FAIL b2b_valid[t+%0d]: got %b expected %b", k, bus.valid, e_valid);
      end
      checks++;
      if (bus.in_raddr !== e_raddr) begin
        errors++; $display("FAIL b2b_in_raddr[t+%0d]: got %0d expected %0d", k, bus.in_raddr, e_raddr);
      end
      checks++;
      if (bus.bin_wen !== e_wen) begin
        errors++; $display("FAIL b2b_wen[t+%0d]: got %b expected %b", k, bus.bin_wen, e_wen);
      end
      checks++;
      if (bus.bin_waddr !== e_waddr) begin
        errors++; $display("FAIL b2b_waddr[t+%0d]: got %h expected %h", k, bus.bin_waddr, e_waddr);
      end
      checks++;
      if (bus.bin_wdata !== e_wdata) begin
        errors++; $display("FAIL b2b_wdata[t+%0d]: got %0d expected %0d", k, bus.bin_wdata, e_wdata);
      end
      if (k < 9) step();
    end
    checks++;
    if (bmem[8'h55] !== 32'd6) begin
      errors++; $display("FAIL b2b_bin55: got %0d expected 6", bmem[8'h55]);
    end
  endtask

  task automatic test_start_ignored();
    int t0, vc;
    for (int k = 0; k < 256; k++) bmem[k] <= 32'h0;
    smem[0] <= 8'd1; smem[1] <= 8'd2; smem[2] <= 8'd1; smem[3] <= 8'd2;
    smem[4] <= 8'd5; smem[5] <= 8'd5; smem[6] <= 8'd5; smem[7] <= 8'd1;
    do_start(1'b0, 1'b0, 5);
    t0 = t_start;
    step();
    bus.clear_first = 1'b1;
    bus.num_samples = 13'd8;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.clear_first = 1'b0;
    wait_valid(1'b0, 40, vc);
    checks++;
    if (vc !== t0 + 8) begin
      errors++; $display("FAIL ignore_valid_time: got %0d expected %0d", vc, t0 + 8);
    end
    checks++;
    if (bmem[1] !== 32'd2 || bmem[2] !== 32'd2) begin
      errors++; $display("FAIL ignore_bins12: got %0d,%0d expected 2,2", bmem[1], bmem[2]);
    end
    checks++;
    if (bmem[5] !== 32'd1) begin
      errors++; $display("FAIL ignore_bin5: got %0d expected 1", bmem[5]);
    end
  endtask

  task automatic test_reset_mid_run();
    int vc;
    smem[0] <= 8'd3; smem[1] <= 8'd7; smem[2] <= 8'd3; smem[3] <= 8'd3;
    smem[4] <= 8'd9; smem[5] <= 8'd9;
    do_start(1'b0, 1'b0, 6);
    step();
    step();
    checks++;
    if (bus.bin_wen !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_active: got wen=%b busy=%b expected 1 1", bus.bin_wen, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.saturated !== 1'b0) begin
      errors++; $display("FAIL midrst_status: got %b%b%b expected 000", bus.busy, bus.valid, bus.saturated);
    end
    checks++;
    if (bus.bin_wen !== 1'b0 || bus.bin_waddr !== 8'h0 || bus.bin_wdata !== 32'h0 ||
        bus.in_raddr !== 12'h0 || bus.bin_raddr !== 8'h0) begin
      errors++; $display("FAIL midrst_outputs: got wen=%b waddr=%h wdata=%h in_raddr=%h bin_raddr=%h expected all 0",
                         bus.bin_wen, bus.bin_waddr, bus.bin_wdata, bus.in_raddr, bus.bin_raddr);
    end
    step();
    step();
    rst = 1'b1;
    step();
    do_start(1'b0, 1'b1, 4);
    wait_valid(1'b0, 400, vc);
    checks++;
    if (vc !== t_start + 263) begin
      errors++; $display("FAIL midrst_valid_time: got %0d expected %0d", vc, t_start + 263);
    end
    check_bins_3_7("midrst");
  endtask

  task automatic test_saturation();
    int vc;
    for (int k = 0; k < 256; k++) bmem_s[k] <= 4'hA;
    for (int k = 0; k < 20; k++) smem_s[k] <= 8'd9;
    do_start(1'b1, 1'b1, 20);
    wait_valid(1'b1, 400, vc);
    checks++;
    if (vc !== t_start + 279) begin
      errors++; $display("FAIL sat_valid_time: got %0d expected %0d", vc, t_start + 279);
    end
    checks++;
    if (bmem_s[9] !== 4'd15) begin
      errors++; $display("FAIL sat_bin9: got %0d expected 15", bmem_s[9]);
    end
    checks++;
    if (bmem_s[8] !== 4'd0) begin
      errors++; $display("FAIL sat_bin8_cleared: got %0d expected 0", bmem_s[8]);
    end
    checks++;
    if (bus_s.saturated !== 1'b1) begin
      errors++; $display("FAIL sat_flag_set: got %b expected 1", bus_s.saturated);
    end
    do_start(1'b1, 1'b0, 0);
    checks++;
    if (bus_s.saturated !== 1'b0 || bus_s.valid !== 1'b1) begin
      errors++; $display("FAIL sat_flag_cleared: got sat=%b valid=%b expected 0 1", bus_s.saturated, bus_s.valid);
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.clear_first   = 1'b0;
    bus.num_samples   = '0;
    bus_s.start       = 1'b0;
    bus_s.clear_first = 1'b0;
    bus_s.num_samples = '0;
    for (int k = 0; k < 4096; k++) begin
      smem[k]   = 8'h00;
      smem_s[k] = 8'h00;
    end
    for (int k = 0; k < 256; k++) begin
      bmem[k]   = 32'h0;
      bmem_s[k] = 4'h0;
    end
    #2;
    test_reset();
    test_zero_samples();
    test_clear_run();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
